barrel_unrotate: RTL

- Inverse companion to the team's barrel rotator (`barrel`): takes an N-word vector plus its rotation amount and restores the original word order.
- Placed downstream of `barrel` on the same start/ready/valid handshake. A forward rotate followed by this block is the identity.
- Fully pipelined: one log2(N) stage per rotation bit, one vector per cycle, with backpressure.

---
 rtl/barrel_unrotate_if.sv | 26 ++
 rtl/barrel_unrotate.sv | 75 +++++++
 2 files changed

// File: rtl/barrel_unrotate_if.sv
// Handshake bundle between a vector source, barrel_unrotate and its consumer.
// slave is the unrotator's view; master is the source/sink view.
interface barrel_unrotate_if #(
    parameter int unsigned N            = 32,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned Rotation_wid = $clog2(N)
);
    logic [N*WIDTH-1:0]      ip1;
    logic [Rotation_wid-1:0] rot;
    logic                    start;
    logic                    dpRdy;
    logic [N*WIDTH-1:0]      op;
    logic                    opValid;
    logic                    opRdy;
    logic [15:0]             doneCnt;

    modport slave (
        input  ip1, rot, start, opRdy,
        output dpRdy, op, opValid, doneCnt
    );

    modport master (
        output ip1, rot, start, opRdy,
        input  dpRdy, op, opValid, doneCnt
    );
endinterface

// File: rtl/barrel_unrotate.sv
// Pipelined inverse barrel rotator: op word j = ip1 word (j - rot) mod N.
// One register stage per rotation bit; the whole pipe stalls as a unit under backpressure.
module barrel_unrotate #(
    parameter int unsigned N            = 32,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned Rotation_wid = $clog2(N)
) (
    input logic              clk,
    input logic              rst,
    barrel_unrotate_if.slave bus
);
    localparam int unsigned VecW = N * WIDTH;
    localparam int unsigned Last = Rotation_wid - 1;

    logic        advance;
    logic [15:0] done_cnt_q;

    for (genvar k = 0; k < Rotation_wid; k++) begin : g_stage
        localparam int unsigned Shift = 1 << k;

        logic [VecW-1:0]         src;
        logic [VecW-1:0]         shifted;
        logic [VecW-1:0]         data_q;
        logic [Rotation_wid-1:0] rot_src;
        logic [Rotation_wid-1:0] rot_q;
        logic                    valid_src;
        logic                    valid_q;
        logic                    unused_rot_q;

        if (k == 0) begin : g_head
            assign src       = bus.ip1;
            assign rot_src   = bus.rot;
            assign valid_src = bus.start;
        end else begin : g_body
            assign src       = g_stage[k-1].data_q;
            assign rot_src   = g_stage[k-1].rot_q;
            assign valid_src = g_stage[k-1].valid_q;
        end

        // Output word j takes input word (j - 2^k) mod N.
        for (genvar j = 0; j < N; j++) begin : g_word
            assign shifted[j*WIDTH +: WIDTH] = src[((j + N - Shift) % N)*WIDTH +: WIDTH];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                rot_q   <= '0;
                valid_q <= 1'b0;
            end else if (advance) begin
                data_q  <= rot_src[k] ? shifted : src;
                rot_q   <= rot_src;
                valid_q <= valid_src;
            end
        end

        // Bits already consumed upstream (and all bits in the last stage) are dead here.
        assign unused_rot_q = ^rot_q;
    end

    assign advance = !g_stage[Last].valid_q || bus.opRdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_q <= '0;
        end else if (g_stage[Last].valid_q && bus.opRdy) begin
            done_cnt_q <= done_cnt_q + 16'd1;
        end
    end

    assign bus.dpRdy   = advance;
    assign bus.opValid = g_stage[Last].valid_q;
    assign bus.op      = g_stage[Last].valid_q ? g_stage[Last].data_q : '0;
    assign bus.doneCnt = done_cnt_q;
endmodule
